uart_rx_packer: RTL and testbench
=================================

UART_RX_PACKER -- requirements
Module: uart_rx_packer

Interface
REQ-001 SHALL have parameter BYTES_PER_WORD, default 4, bytes packed per word (1..4); W = 8*BYTES_PER_WORD.
REQ-002 SHALL have parameter DEPTH, default 4, word-FIFO depth (power of 2, >=2).
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 60000, idle cycles before a partial word is flushed (>=2).
REQ-004 SHALL have parameter MSB_FIRST, default 1; 1 = first byte in bits [W-1:W-8], 0 = first byte in bits [7:0].
REQ-005 SHALL have parameter IRQ_THRESH, default 1, FIFO level at which irq asserts (1..DEPTH).
REQ-006 clk  in  1  single clock; all logic on the rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 i_byte_vld  in  1  one-cycle strobe from the UART receiver: i_byte is valid.
REQ-009 i_byte  in  8  received byte.
REQ-010 i_frame_err  in  1  frame error qualifier for the current i_byte_vld.
REQ-011 i_word_rd  in  1  pop FIFO head; ignored when empty.
REQ-012 i_irq_en  in  1  interrupt enable.
REQ-013 i_clr  in  1  clears sticky o_ovf and o_frame_err.
REQ-014 o_word  out  W  FIFO head word (show-ahead); 0 when empty.
REQ-015 o_word_num  out  3  valid byte count of head word (1..BYTES_PER_WORD); 0 when empty.
REQ-016 o_word_vld  out  1  FIFO non-empty.
REQ-017 o_level  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-018 irq  out  1  registered: i_irq_en && o_level >= IRQ_THRESH.
REQ-019 o_ovf  out  1  sticky: a completed word was dropped.
REQ-020 o_frame_err  out  1  sticky frame error flag.

Function
REQ-021 Packer FSM SHALL have states IDLE (no partial bytes), FILL (1..BYTES_PER_WORD-1 bytes held), FLUSH (one-cycle timeout push).
REQ-022 Accepted byte SHALL go to lane cnt (MSB_FIRST ordering); cnt increments; IDLE->FILL on the first byte.
REQ-023 Byte completing a word SHALL push {word, BYTES_PER_WORD} on the same edge; o_word_vld/o_level update the next cycle; FSM -> IDLE.
REQ-024 In FILL, idle counter SHALL clear on every accepted byte and otherwise increment; after IDLE_TIMEOUT consecutive byte-free cycles FSM -> FLUSH.
REQ-025 FLUSH SHALL push the partial word with unused lanes zero and o_word_num = cnt, then -> IDLE; a byte arriving in FLUSH SHALL start a new word (cnt=1, -> FILL).
REQ-026 Idle counter SHALL hold 0 in IDLE; no flush ever occurs with cnt=0.
REQ-027 Push while full with no simultaneous pop SHALL drop the word, set o_ovf, and clear the partial; push and pop in the same cycle when full SHALL succeed, level unchanged.
REQ-028 Pop and push same cycle when not full SHALL leave o_level unchanged.
REQ-029 i_clr SHALL clear sticky flags next cycle; a set event in the same cycle wins.
REQ-030 irq SHALL deassert the cycle after o_level drops below IRQ_THRESH or i_irq_en falls.

Reset
REQ-031 rst_n low SHALL force immediately: FSM IDLE, cnt 0, idle counter 0, FIFO empty, all outputs 0.
REQ-032 Reset mid-word SHALL discard the partial word; no flush after release.

Configuration
REQ-033 With UART_RX_FERR_EN defined, a byte with i_frame_err=1 SHALL NOT be packed, SHALL set o_frame_err, and SHALL NOT clear the idle counter.
REQ-034 Without UART_RX_FERR_EN, i_frame_err SHALL be ignored (byte packed) and o_frame_err SHALL be tied 0.

Structure
REQ-035 Package uart_pkg SHALL hold the packer state enum and the lane-index/count width helpers.
REQ-036 Word storage SHALL be sub-module uart_word_fifo (synchronous, show-ahead, DEPTH x (W+3)).

Verification (BYTES_PER_WORD=4, DEPTH=4, IDLE_TIMEOUT=16, IRQ_THRESH=1, i_irq_en=1)
REQ-037 Bytes 0x11,0x22,0x33,0x44 -> o_word=0x11223344, o_word_num=4, o_level=1, irq=1; pop -> irq=0.
REQ-038 0xAA,0xBB then 16 idle cycles -> o_word=0xAABB0000, o_word_num=2; a byte in the FLUSH cycle starts a new word.
REQ-039 Fill 4 words, 5th completes with no pop -> o_ovf=1, o_level=4; repeated with pop the same cycle -> o_ovf=0, o_level=4.
REQ-040 UART_RX_FERR_EN: 0x55 with i_frame_err=1, then 0x01..0x04 -> o_frame_err=1, o_word=0x01020304; i_clr -> o_frame_err=0.
REQ-041 MSB_FIRST=0: 0x11,0x22,0x33,0x44 -> o_word=0x44332211.
REQ-042 rst_n pulse after 2 bytes -> o_level=0, no flush; next 4 bytes yield a single clean word.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive packer.
//   pack_state_e : packer FSM states (idle / partial word held / timeout flush)
//   CntW         : width of the per-word byte counter (covers 0..4)
//   lane_of()    : byte index -> lane index mapping for either byte order
//   idle_cnt_w() : width of the idle-cycle counter for a given timeout
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StFlush = 2'd2
    } pack_state_e;

    localparam int unsigned CntW = 3;

    // The mapping is its own inverse, so it also converts lane -> byte index.
    function automatic int unsigned lane_of(input int unsigned idx, input int unsigned bpw,
                                            input bit msb_first);
        return msb_first ? (bpw - 1 - idx) : idx;
    endfunction

    // Counter runs 0..timeout-1.
    function automatic int unsigned idle_cnt_w(input int unsigned timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// uart_word_fifo: synchronous show-ahead FIFO holding packed words.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   wr_en      : push request; accepted when not full or when popping the same cycle
//   wr_data    : word to push
//   rd_en      : pop head; ignored when empty
//   rd_data    : head entry, zero when empty
//   vld        : FIFO non-empty
//   level      : occupancy
//   drop       : push rejected because full with no simultaneous pop
module uart_word_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LVL_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             vld,
    output logic [LVL_W-1:0] level,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic             full, empty, do_pop, do_push;

    assign full    = (cnt_q == LVL_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = rd_en && !empty;
    // When full, the slot being freed by the pop is the one the write pointer lands on.
    assign do_push = wr_en && (!full || do_pop);
    assign drop    = wr_en && full && !do_pop;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + LVL_W'(1);
            2'b01:   cnt_d = cnt_q - LVL_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rptr_q];
    assign vld     = !empty;
    assign level   = cnt_q;

endmodule

// File: rtl/uart_rx_packer.sv
// uart_rx_packer: packs received UART bytes into words and queues them in a FIFO.
// A partial word is flushed after IDLE_TIMEOUT byte-free cycles.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_byte_vld   : byte strobe;  i_byte : byte;  i_frame_err : frame error qualifier
//   i_word_rd    : pop FIFO head;  i_irq_en : interrupt enable;  i_clr : clear sticky flags
//   o_word, o_word_num, o_word_vld, o_level : FIFO head word, its byte count, non-empty, level
//   irq          : registered i_irq_en && o_level >= IRQ_THRESH
//   o_ovf        : sticky, a completed word was dropped
//   o_frame_err  : sticky frame error flag
// Build option: define UART_RX_FERR_EN to discard bytes flagged with i_frame_err and record
// them in o_frame_err; otherwise i_frame_err is ignored and o_frame_err is tied low.
module uart_rx_packer
    import uart_pkg::*;
#(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned IDLE_TIMEOUT   = 60000,
    parameter int unsigned MSB_FIRST      = 1,
    parameter int unsigned IRQ_THRESH     = 1,
    localparam int unsigned W     = 8 * BYTES_PER_WORD,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_byte_vld,
    input  logic [7:0]       i_byte,
    input  logic             i_frame_err,
    input  logic             i_word_rd,
    input  logic             i_irq_en,
    input  logic             i_clr,
    output logic [W-1:0]     o_word,
    output logic [2:0]       o_word_num,
    output logic             o_word_vld,
    output logic [LVL_W-1:0] o_level,
    output logic             irq,
    output logic             o_ovf,
    output logic             o_frame_err
);

    localparam int unsigned     IdleW    = idle_cnt_w(IDLE_TIMEOUT);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_TIMEOUT - 1);
    localparam logic [CntW-1:0]  BpwC    = CntW'(BYTES_PER_WORD);

    pack_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]      buf_q, buf_d, nxt_word;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic              byte_acc;
    logic              push;
    logic [W-1:0]      push_word;
    logic [CntW-1:0]   push_num;
    logic [W+CntW-1:0] fifo_rd;
    logic              fifo_drop;
    logic              irq_q, ovf_q;

    function automatic logic [W-1:0] put_byte(input logic [W-1:0] w, input logic [CntW-1:0] idx,
                                              input logic [7:0] b);
        logic [W-1:0] r;
        r = w;
        for (int unsigned l = 0; l < BYTES_PER_WORD; l++) begin
            if (idx == CntW'(lane_of(l, BYTES_PER_WORD, MSB_FIRST != 0))) r[l*8 +: 8] = b;
        end
        return r;
    endfunction

`ifdef UART_RX_FERR_EN
    logic ferr_q;
    assign byte_acc = i_byte_vld && !i_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           ferr_q <= 1'b0;
        else if (i_byte_vld && i_frame_err)  ferr_q <= 1'b1;
        else if (i_clr)                      ferr_q <= 1'b0;
    end

    assign o_frame_err = ferr_q;
`else
    logic unused_frame_err;
    assign unused_frame_err = i_frame_err;
    assign byte_acc         = i_byte_vld;
    assign o_frame_err      = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        idle_d    = idle_q;
        push      = 1'b0;
        push_word = '0;
        push_num  = '0;
        nxt_word  = put_byte(buf_q, cnt_q, i_byte);
        case (state_q)
            StIdle, StFill: begin
                if (byte_acc) begin
                    idle_d = '0;
                    if (cnt_q + CntW'(1) == BpwC) begin
                        push      = 1'b1;
                        push_word = nxt_word;
                        push_num  = BpwC;
                        buf_d     = '0;
                        cnt_d     = '0;
                        state_d   = StIdle;
                    end else begin
                        buf_d   = nxt_word;
                        cnt_d   = cnt_q + CntW'(1);
                        state_d = StFill;
                    end
                end else if (state_q == StFill) begin
                    if (idle_q == IdleMax) begin
                        idle_d  = '0;
                        state_d = StFlush;
                    end else begin
                        idle_d = idle_q + IdleW'(1);
                    end
                end
            end
            StFlush: begin
                push      = 1'b1;
                push_word = buf_q;
                push_num  = cnt_q;
                idle_d    = '0;
                // A byte landing on the flush cycle opens the next word.
                if (byte_acc) begin
                    buf_d   = put_byte('0, '0, i_byte);
                    cnt_d   = CntW'(1);
                    state_d = StFill;
                end else begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                buf_d   = '0;
                idle_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            buf_q   <= '0;
            idle_q  <= '0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            idle_q  <= idle_d;
            irq_q   <= i_irq_en && (o_level >= LVL_W'(IRQ_THRESH));
            if (fifo_drop)  ovf_q <= 1'b1;
            else if (i_clr) ovf_q <= 1'b0;
        end
    end

    uart_word_fifo #(
        .WIDTH (W + CntW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data ({push_num, push_word}),
        .rd_en   (i_word_rd),
        .rd_data (fifo_rd),
        .vld     (o_word_vld),
        .level   (o_level),
        .drop    (fifo_drop)
    );

    assign o_word     = fifo_rd[W-1:0];
    assign o_word_num = fifo_rd[W+CntW-1:W];
    assign irq        = irq_q;
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Bench for uart_rx_packer: two instances (MSB-first and LSB-first) share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_uart_rx_packer;

    localparam int BPW = 4;
    localparam int DEPTH = 4;
    localparam int TMO = 16;
    localparam int THR = 1;
`ifdef UART_RX_FERR_EN
    localparam bit FERR = 1'b1;
`else
    localparam bit FERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_vld = 1'b0;
    logic [7:0]  byte_d = 8'h00;
    logic        frame_err = 1'b0;
    logic        word_rd = 1'b0;
    logic        irq_en = 1'b1;
    logic        clr = 1'b0;

    logic [31:0] m_word, l_word;
    logic [2:0]  m_num, l_num, m_level, l_level;
    logic        m_vld, l_vld, m_irq, l_irq, m_ovf, l_ovf, m_ferr, l_ferr;

    uart_rx_packer #(
        .BYTES_PER_WORD (BPW), .DEPTH (DEPTH), .IDLE_TIMEOUT (TMO), .MSB_FIRST (1),
        .IRQ_THRESH (THR)
    ) dut (
        .clk (clk), .rst_n (rst_n), .i_byte_vld (byte_vld), .i_byte (byte_d),
        .i_frame_err (frame_err), .i_word_rd (word_rd), .i_irq_en (irq_en), .i_clr (clr),
        .o_word (m_word), .o_word_num (m_num), .o_word_vld (m_vld), .o_level (m_level),
        .irq (m_irq), .o_ovf (m_ovf), .o_frame_err (m_ferr)
    );

    uart_rx_packer #(
        .BYTES_PER_WORD (BPW), .DEPTH (DEPTH), .IDLE_TIMEOUT (TMO), .MSB_FIRST (0),
        .IRQ_THRESH (THR)
    ) dut_lsb (
        .clk (clk), .rst_n (rst_n), .i_byte_vld (byte_vld), .i_byte (byte_d),
        .i_frame_err (frame_err), .i_word_rd (word_rd), .i_irq_en (irq_en), .i_clr (clr),
        .o_word (l_word), .o_word_num (l_num), .o_word_vld (l_vld), .o_level (l_level),
        .irq (l_irq), .o_ovf (l_ovf), .o_frame_err (l_ferr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: FIFO contents as queues, partial word as a byte queue.
    logic [31:0] q_msb[$];
    logic [31:0] q_lsb[$];
    int          q_num[$];
    logic [7:0]  part[$];
    int          r_idle;
    bit          r_flush_due, r_ovf, r_ferr, r_irq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_msb.delete();
        q_lsb.delete();
        q_num.delete();
        part.delete();
        r_idle = 0;
        r_flush_due = 1'b0;
        r_ovf = 1'b0;
        r_ferr = 1'b0;
        r_irq = 1'b0;
    endtask

    task automatic model_step();
        bit acc, pop, push, full;
        logic [31:0] wm, wl;
        int n;
        acc  = byte_vld && !(FERR && frame_err);
        pop  = word_rd && (q_msb.size() > 0);
        full = (q_msb.size() == DEPTH);
        push = 1'b0;
        wm = '0;
        wl = '0;
        n = 0;
        if (r_flush_due || (acc && part.size() == BPW - 1)) begin
            if (!r_flush_due) part.push_back(byte_d);
            push = 1'b1;
            n = part.size();
            for (int i = 0; i < part.size(); i++) begin
                wm[(BPW-1-i)*8 +: 8] = part[i];
                wl[i*8 +: 8] = part[i];
            end
            part.delete();
            r_idle = 0;
            if (r_flush_due && acc) part.push_back(byte_d);
            r_flush_due = 1'b0;
        end else if (acc) begin
            part.push_back(byte_d);
            r_idle = 0;
        end else if (part.size() > 0) begin
            r_idle++;
            if (r_idle == TMO) begin
                r_flush_due = 1'b1;
                r_idle = 0;
            end
        end
        r_irq = irq_en && (q_msb.size() >= THR);
        if (pop) begin
            void'(q_msb.pop_front());
            void'(q_lsb.pop_front());
            void'(q_num.pop_front());
        end
        if (push && full && !pop) begin
            r_ovf = 1'b1;
        end else begin
            if (push) begin
                q_msb.push_back(wm);
                q_lsb.push_back(wl);
                q_num.push_back(n);
            end
            if (clr) r_ovf = 1'b0;
        end
        if (FERR && byte_vld && frame_err) r_ferr = 1'b1;
        else if (clr) r_ferr = 1'b0;
    endtask

    task automatic compare_all();
        logic [31:0] ew, el, en;
        bit ev;
        ev = q_msb.size() > 0;
        ew = ev ? q_msb[0] : 32'h0;
        el = ev ? q_lsb[0] : 32'h0;
        en = ev ? q_num[0] : 0;
        check_eq("word", m_word, ew);
        check_eq("word_num", 32'(m_num), en);
        check_eq("word_vld", 32'(m_vld), 32'(ev));
        check_eq("level", 32'(m_level), q_msb.size());
        check_eq("irq", 32'(m_irq), 32'(r_irq));
        check_eq("ovf", 32'(m_ovf), 32'(r_ovf));
        check_eq("frame_err", 32'(m_ferr), 32'(r_ferr));
        check_eq("lsb_word", l_word, el);
        check_eq("lsb_word_num", 32'(l_num), en);
        check_eq("lsb_level", 32'(l_level), q_msb.size());
        check_eq("lsb_irq", 32'(l_irq), 32'(r_irq));
        check_eq("lsb_ovf", 32'(l_ovf), 32'(r_ovf));
        check_eq("lsb_frame_err", 32'(l_ferr), 32'(r_ferr));
    endtask

    task automatic cycle(input bit v, input logic [7:0] b, input bit f, input bit r, input bit c);
        byte_vld = v;
        byte_d = b;
        frame_err = f;
        word_rd = r;
        clr = c;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        byte_vld = 1'b0;
        frame_err = 1'b0;
        word_rd = 1'b0;
        clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous pulse between clock edges; outputs must clear without a clock.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #2;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Full word, both byte orders; irq follows level one cycle later.
        cycle(1, 8'h11, 0, 0, 0);
        cycle(1, 8'h22, 0, 0, 0);
        cycle(1, 8'h33, 0, 0, 0);
        cycle(1, 8'h44, 0, 0, 0);
        idle(1);
        check_eq("basic_word", m_word, 32'h11223344);
        check_eq("basic_num", 32'(m_num), 32'd4);
        check_eq("basic_level", 32'(m_level), 32'd1);
        check_eq("basic_irq", 32'(m_irq), 32'd1);
        check_eq("basic_lsb_word", l_word, 32'h44332211);
        cycle(0, 8'h00, 0, 1, 0);
        idle(1);
        check_eq("basic_irq_after_pop", 32'(m_irq), 32'd0);

        // Timeout flush, with a new byte arriving on the flush cycle.
        cycle(1, 8'hAA, 0, 0, 0);
        cycle(1, 8'hBB, 0, 0, 0);
        idle(TMO - 1);
        check_eq("flush_not_early", 32'(m_vld), 32'd0);
        for (int k = 0; k < 40 && !r_flush_due; k++) idle(1);
        cycle(1, 8'hC3, 0, 0, 0);
        check_eq("flush_word", m_word, 32'hAABB0000);
        check_eq("flush_num", 32'(m_num), 32'd2);
        cycle(0, 8'h00, 0, 1, 0);
        for (int k = 0; k < 40 && !r_flush_due; k++) idle(1);
        idle(1);
        check_eq("flush2_word", m_word, 32'hC3000000);
        check_eq("flush2_num", 32'(m_num), 32'd1);

        // Overflow: fifth word without a pop is dropped; with a pop it is accepted.
        pulse_reset();
        for (int i = 0; i < 5 * BPW; i++) cycle(1, 8'(i + 1), 0, 0, 0);
        check_eq("ovf_set", 32'(m_ovf), 32'd1);
        check_eq("ovf_level", 32'(m_level), 32'd4);
        cycle(0, 8'h00, 0, 0, 1);
        check_eq("ovf_clr", 32'(m_ovf), 32'd0);
        for (int i = 0; i < BPW - 1; i++) cycle(1, 8'h60 + 8'(i), 0, 0, 0);
        cycle(1, 8'h6F, 0, 1, 0);
        check_eq("full_pushpop_ovf", 32'(m_ovf), 32'd0);
        check_eq("full_pushpop_level", 32'(m_level), 32'd4);

        // Frame error handling.
        pulse_reset();
        cycle(1, 8'h55, 1, 0, 0);
        for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 0, 0);
`ifdef UART_RX_FERR_EN
        check_eq("ferr_flag", 32'(m_ferr), 32'd1);
        check_eq("ferr_word", m_word, 32'h01020304);
        cycle(0, 8'h00, 0, 0, 1);
        check_eq("ferr_clr", 32'(m_ferr), 32'd0);
`else
        check_eq("ferr_ignored_flag", 32'(m_ferr), 32'd0);
        check_eq("ferr_ignored_word", m_word, 32'h55010203);
`endif

        // Reset mid-word discards the partial; no flush afterwards.
        pulse_reset();
        cycle(1, 8'hDE, 0, 0, 0);
        cycle(1, 8'hAD, 0, 0, 0);
        pulse_reset();
        idle(TMO + 4);
        check_eq("rst_no_flush", 32'(m_level), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1, 8'hA0 + 8'(i), 0, 0, 0);
        idle(TMO + 4);
        check_eq("rst_clean_word", m_word, 32'hA0A1A2A3);
        check_eq("rst_clean_level", 32'(m_level), 32'd1);

        // Randomized traffic with phases of dense, sparse and backpressured bytes.
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            int ph;
            int pv;
            int pr;
            ph = (i / 200) % 3;
            pv = (ph == 0) ? 50 : (ph == 1) ? 8 : 90;
            pr = (ph == 2) ? 10 : 30;
            if ($urandom_range(99) < 5) irq_en = ~irq_en;
            cycle($urandom_range(99) < pv, 8'($urandom), $urandom_range(99) < 10,
                  $urandom_range(99) < pr, $urandom_range(99) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
